// File: rtl/cellram_async_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cellram_async_ctrl_pkg                                       |
// | Description : Shared definitions for the asynchronous CellularRAM          |
// |               controller: FSM state encoding, timer width, and the         |
// |               configuration-register select values carried on the address. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package cellram_async_ctrl_pkg;

    // Width of the shared access/power-up down-counter.
    localparam int c_CNT_W = 24;

    typedef enum logic [2:0] {
        ST_POWERUP  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ADDR     = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_RECOVER  = 3'd6
    } state_t;

    // Register select field for config-register accesses (address bits 19:18).
    localparam int          c_SEL_POS = 18;
    localparam logic [1:0]  c_SEL_RCR = 2'b00;
    localparam logic [1:0]  c_SEL_BCR = 2'b10;

    // Converts a cycle-count parameter to the counter width.
    function automatic logic [c_CNT_W-1:0] cyc(input int n);
        return c_CNT_W'(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cellram_async_ctrl_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cellram_async_ctrl_timer                                     |
// | Description : Loadable down-counter shared by all timed controller states. |
// |               Loading N keeps o_done low for N-1 cycles, so a state that   |
// |               loads N and leaves on o_done lasts exactly N cycles.         |
// | Ports       : clk, reset (async, active-high)                              |
// |               i_load  - load i_value this cycle                            |
// |               i_value - count to load                                      |
// |               o_done  - current count <= 1                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cellram_async_ctrl_timer
    import cellram_async_ctrl_pkg::*;
#(
    parameter logic [c_CNT_W-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [c_CNT_W-1:0] i_value,
    output logic               o_done
);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // A load of 0 also reads as done, so a zero power-up wait is skipped.
    assign o_done = (r_cnt <= c_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/cellram_async_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cellram_async_ctrl                                           |
// | Description : Host-side asynchronous-mode CellularRAM controller. Accepts  |
// |               single-word read / write / config-register requests on a     |
// |               valid/ready port and sequences the device strobes with       |
// |               cycle-counted timing. Reads return on a one-cycle strobe.    |
// | Ports       : clk, reset (async, active-high), init_done                   |
// |               req_valid/ready/write/cre/addr/wdata/be - request port       |
// |               rsp_valid/rsp_rdata                     - read response      |
// |               ram_* - device pins (all registered), ram_dq_i sampled DQ    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cellram_async_ctrl
    import cellram_async_ctrl_pkg::*;
#(
    parameter int ADDR_BITS  = 23,
    parameter int DQ_BITS    = 16,
    parameter int BY_BITS    = 2,
    parameter int T_PU_CYC   = 15000,
    parameter int T_AVS_CYC  = 1,
    parameter int T_WP_CYC   = 4,
    parameter int T_RD_CYC   = 6,
    parameter int T_HOLD_CYC = 1,
    parameter int T_REC_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 init_done,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_cre,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DQ_BITS-1:0]   req_wdata,
    input  logic [BY_BITS-1:0]   req_be,
    output logic                 rsp_valid,
    output logic [DQ_BITS-1:0]   rsp_rdata,
    output logic                 ram_clk,
    output logic                 ram_ce_n,
    output logic                 ram_adv_n,
    output logic                 ram_oe_n,
    output logic                 ram_we_n,
    output logic                 ram_ub_n,
    output logic                 ram_lb_n,
    output logic                 ram_cre,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DQ_BITS-1:0]   ram_dq_o,
    output logic                 ram_dq_oe,
    input  logic [DQ_BITS-1:0]   ram_dq_i
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_write;
    logic               w_accept;
    logic               w_tmr_load;
    logic [c_CNT_W-1:0] w_tmr_val;
    logic               w_tmr_done;

    assign ram_clk   = 1'b0;
    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = (r_state == ST_IDLE) && req_valid;

    cellram_async_ctrl_timer #(
        .RST_VAL (cyc(T_PU_CYC))
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_POWERUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every timed state loads the timer for its successor on the exit edge.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        case (r_state)
            ST_POWERUP: begin
                if (w_tmr_done) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_ADDR;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = cyc(T_AVS_CYC);
                end
            end
            ST_ADDR: begin
                if (w_tmr_done) begin
                    w_tmr_load = 1'b1;
                    if (r_write) begin
                        w_state_nxt = ST_WR_PULSE;
                        w_tmr_val   = cyc(T_WP_CYC);
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                        w_tmr_val   = cyc(T_RD_CYC);
                    end
                end
            end
            ST_WR_PULSE: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_WR_HOLD;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = cyc(T_HOLD_CYC);
                end
            end
            ST_WR_HOLD, ST_RD_WAIT: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_RECOVER;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = cyc(T_REC_CYC);
                end
            end
            ST_RECOVER: begin
                if (w_tmr_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_POWERUP;
        endcase
    end

    // Control, init and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write   <= 1'b0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (w_accept) r_write <= req_write;
            if (r_state == ST_POWERUP && w_tmr_done) init_done <= 1'b1;
            // Sample DQ on the final OE# low edge, while the device still drives.
            if (r_state == ST_RD_WAIT && w_tmr_done) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= ram_dq_i;
            end
        end
    end

    // Pin registers follow the next state so every pin changes with the state.
    // Address, CRE, data and lanes are captured only at acceptance and then held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_ce_n  <= 1'b1;
            ram_adv_n <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_ub_n  <= 1'b1;
            ram_lb_n  <= 1'b1;
            ram_cre   <= 1'b0;
            ram_addr  <= '0;
            ram_dq_o  <= '0;
            ram_dq_oe <= 1'b0;
        end else if (w_accept) begin
            ram_ce_n  <= 1'b0;
            ram_adv_n <= 1'b0;
            ram_cre   <= req_cre;
            ram_addr  <= req_addr;
            ram_dq_o  <= req_wdata;
            // Config writes carry their value on the address bus, so DQ stays off.
            ram_dq_oe <= req_write & ~req_cre;
            if (req_write && !req_cre) begin
                ram_ub_n <= ~req_be[BY_BITS-1];
                ram_lb_n <= ~req_be[0];
            end else begin
                ram_ub_n <= 1'b0;
                ram_lb_n <= 1'b0;
            end
        end else begin
            case (w_state_nxt)
                ST_ADDR: ;
                ST_WR_PULSE: begin
                    ram_adv_n <= 1'b1;
                    ram_we_n  <= 1'b0;
                end
                ST_WR_HOLD: begin
                    ram_we_n  <= 1'b1;
                end
                ST_RD_WAIT: begin
                    ram_adv_n <= 1'b1;
                    ram_oe_n  <= 1'b0;
                end
                default: begin
                    ram_ce_n  <= 1'b1;
                    ram_adv_n <= 1'b1;
                    ram_oe_n  <= 1'b1;
                    ram_we_n  <= 1'b1;
                    ram_ub_n  <= 1'b1;
                    ram_lb_n  <= 1'b1;
                    ram_cre   <= 1'b0;
                    ram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cellram_async_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cellram_async_ctrl                                        |
// | Description : Self-checking bench for cellram_async_ctrl with a small     |
// |               CellularRAM behavioural model on the pins. Read responses    |
// |               are scoreboarded (data + arrival cycle); pin behaviour is    |
// |               checked through per-access observation counters.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cellram_async_ctrl;
    import cellram_async_ctrl_pkg::*;

    localparam int AB     = 23;
    localparam int DB     = 16;
    localparam int BB     = 2;
    localparam int T_PU   = 100;
    localparam int T_AVS  = 1;
    localparam int T_WP   = 4;
    localparam int T_RD   = 6;
    localparam int T_HOLD = 1;
    localparam int T_REC  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init_done, req_ready, rsp_valid;
    logic          req_valid = 1'b0, req_write = 1'b0, req_cre = 1'b0;
    logic [AB-1:0] req_addr = '0;
    logic [DB-1:0] req_wdata = '0;
    logic [BB-1:0] req_be = '0;
    logic [DB-1:0] rsp_rdata;
    logic          ram_clk, ram_ce_n, ram_adv_n, ram_oe_n, ram_we_n;
    logic          ram_ub_n, ram_lb_n, ram_cre, ram_dq_oe;
    logic [AB-1:0] ram_addr;
    logic [DB-1:0] ram_dq_o, ram_dq_i;

    cellram_async_ctrl #(
        .ADDR_BITS(AB), .DQ_BITS(DB), .BY_BITS(BB), .T_PU_CYC(T_PU),
        .T_AVS_CYC(T_AVS), .T_WP_CYC(T_WP), .T_RD_CYC(T_RD),
        .T_HOLD_CYC(T_HOLD), .T_REC_CYC(T_REC)
    ) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_cre(req_cre), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_clk(ram_clk), .ram_ce_n(ram_ce_n), .ram_adv_n(ram_adv_n),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_ub_n(ram_ub_n),
        .ram_lb_n(ram_lb_n), .ram_cre(ram_cre), .ram_addr(ram_addr),
        .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_dq_i(ram_dq_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- CellularRAM model (DQ bus resolved as a mux) ----------
    logic [15:0]   mem [0:255];
    logic [AB-1:0] m_bcr = '0, m_rcr = '0;
    logic          m_drive;
    logic [15:0]   m_data;

    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    assign m_drive  = !ram_ce_n && !ram_oe_n && ram_we_n;
    assign m_data   = ram_cre ? m_bcr[15:0] : mem[ram_addr[7:0]];
    assign ram_dq_i = ram_dq_oe ? ram_dq_o : (m_drive ? m_data : 16'h0000);

    always @(posedge ram_we_n) begin
        if (!reset && !ram_ce_n) begin
            if (ram_cre) begin
                if (ram_addr[c_SEL_POS +: 2] == c_SEL_BCR) m_bcr = ram_addr;
                else if (ram_addr[c_SEL_POS +: 2] == c_SEL_RCR) m_rcr = ram_addr;
            end else begin
                if (!ram_ub_n) mem[ram_addr[7:0]][15:8] = ram_dq_i[15:8];
                if (!ram_lb_n) mem[ram_addr[7:0]][7:0]  = ram_dq_i[7:0];
            end
        end
    end

    // ---------------- Scoreboard and checking -------------------------------
    typedef struct {
        logic [15:0] data;
        int          at_cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ob_ub, ob_lb, ob_cre, ob_ce, ob_oe, ob_busy, ob_ovl;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic clr_obs();
        ob_ub = 0; ob_lb = 0; ob_cre = 0; ob_ce = 0;
        ob_oe = 0; ob_busy = 0; ob_ovl = 0;
    endtask

    task automatic monitor();
        int   hi_run   = 0;
        logic prev_rsp = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hi_run   = 0;
                prev_rsp = 1'b0;
            end else begin
                if (rsp_valid) begin
                    chk("rsp_single_cycle", prev_rsp, 0);
                    if (sb_q.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.data);
                        chk("rsp_latency_cycle", cyc, e.at_cyc);
                    end
                end
                prev_rsp = rsp_valid;
                if (ram_ce_n) begin
                    hi_run++;
                end else begin
                    if (hi_run > 0) chk("ce_high_gap_ge_trec", hi_run >= T_REC, 1);
                    hi_run = 0;
                end
                if (!ram_ub_n) ob_ub++;
                if (!ram_lb_n) ob_lb++;
                if (ram_cre)   ob_cre++;
                if (!ram_ce_n) ob_ce++;
                if (ram_dq_oe) ob_oe++;
                if (!ram_ce_n && req_ready)  ob_busy++;
                if (ram_dq_oe && !ram_oe_n)  ob_ovl++;
            end
        end
    endtask

    // Called on a negedge. Returns on the negedge after the accept edge.
    // Accept edge k yields rsp_valid seen at the negedge where cyc == k+T_AVS+T_RD.
    task automatic issue(input logic wr, input logic cre, input logic [AB-1:0] a,
                         input logic [DB-1:0] wd, input logic [BB-1:0] be,
                         input logic [DB-1:0] exp_rd, input logic keep);
        int   n = 0;
        exp_t e;
        req_write = wr; req_cre = cre; req_addr = a; req_wdata = wd; req_be = be;
        req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (!wr) begin
            e.data   = exp_rd;
            e.at_cyc = cyc + 1 + T_AVS + T_RD;
            sb_q.push_back(e);
        end
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("idle_timeout", 0, 1);
    endtask

    // ---------------- Stimulus ---------------------------------------------
    logic [AB-1:0] bcr_val;
    int            rel;
    int            n;

    initial begin
        clr_obs();
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_pins",
            {ram_ce_n, ram_adv_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n,
             ram_cre, ram_dq_oe, rsp_valid, init_done, req_ready, ram_clk},
            12'b111111_000000);
        chk("reset_buses", {ram_addr, ram_dq_o, rsp_rdata}, 0);

        // Power-up: init_done rises on the T_PU-th edge after release.
        reset = 1'b0;
        rel   = cyc;
        repeat (T_PU - 1) @(negedge clk);
        chk("pre_init_state", {init_done, req_ready, ram_ce_n, ram_we_n, ram_oe_n, ram_adv_n},
            6'b001111);
        @(negedge clk);
        chk("init_at_tpu", {init_done, req_ready}, 2'b11);
        chk("init_cycle", cyc - rel, T_PU);

        // Full write then read.
        clr_obs();
        issue(1'b1, 1'b0, 23'h000123, 16'hA5C3, 2'b11, 16'h0, 1'b0);
        wait_idle();
        chk("wr_dq_oe_cycles", ob_oe, T_AVS + T_WP + T_HOLD);
        issue(1'b0, 1'b0, 23'h000123, 16'h0, 2'b00, 16'hA5C3, 1'b0);
        wait_idle();
        chk("no_dq_oe_oe_n_overlap", ob_ovl, 0);

        // Low-byte write: upper lane must stay masked.
        clr_obs();
        issue(1'b1, 1'b0, 23'h000123, 16'hFF11, 2'b01, 16'h0, 1'b0);
        wait_idle();
        chk("be01_ub_never_low", ob_ub, 0);
        chk("be01_lb_low_cycles", ob_lb, T_AVS + T_WP + T_HOLD);
        issue(1'b0, 1'b0, 23'h000123, 16'h0, 2'b00, 16'hA511, 1'b0);
        wait_idle();

        // be=00 write runs the cycle but changes nothing.
        clr_obs();
        issue(1'b1, 1'b0, 23'h000124, 16'hBEEF, 2'b00, 16'h0, 1'b0);
        wait_idle();
        chk("be00_lanes_never_low", ob_ub + ob_lb, 0);
        chk("be00_ce_cycles", ob_ce, T_AVS + T_WP + T_HOLD);
        issue(1'b0, 1'b0, 23'h000124, 16'h0, 2'b00, 16'h0000, 1'b0);
        wait_idle();
        issue(1'b1, 1'b0, 23'h000124, 16'h1234, 2'b11, 16'h0, 1'b0);
        wait_idle();

        // Config-register write of a BCR value.
        bcr_val = '0;
        bcr_val[c_SEL_POS +: 2] = c_SEL_BCR;
        bcr_val[15:0] = 16'h1D1F;
        clr_obs();
        issue(1'b1, 1'b1, bcr_val, 16'hFFFF, 2'b11, 16'h0, 1'b0);
        wait_idle();
        chk("cre_ce_cycles", ob_ce, T_AVS + T_WP + T_HOLD);
        chk("cre_high_whole_access", ob_cre, T_AVS + T_WP + T_HOLD);
        chk("cre_dq_oe_never", ob_oe, 0);
        chk("cre_lanes_low", ob_ub + ob_lb, 2 * (T_AVS + T_WP + T_HOLD));
        chk("model_bcr", m_bcr, bcr_val);
        issue(1'b0, 1'b0, 23'h000123, 16'h0, 2'b00, 16'hA511, 1'b0);
        wait_idle();

        // Four reads with req_valid held high throughout.
        clr_obs();
        issue(1'b0, 1'b0, 23'h000123, 16'h0, 2'b00, 16'hA511, 1'b1);
        issue(1'b0, 1'b0, 23'h000124, 16'h0, 2'b00, 16'h1234, 1'b1);
        issue(1'b0, 1'b0, 23'h000000, 16'h0, 2'b00, 16'h0000, 1'b1);
        issue(1'b0, 1'b0, 23'h000123, 16'h0, 2'b00, 16'hA511, 1'b0);
        wait_idle();
        chk("b2b_ready_low_while_busy", ob_busy, 0);
        chk("b2b_ce_low_cycles", ob_ce, 4 * (T_AVS + T_RD));
        chk("b2b_sb_drained", sb_q.size(), 0);

        // Reset in the middle of the WE# pulse.
        issue(1'b1, 1'b0, 23'h000040, 16'h5555, 2'b11, 16'h0, 1'b0);
        n = 0;
        while (ram_we_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ram_we_n) chk("we_pulse_timeout", 0, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_wr_pins", {ram_we_n, ram_ce_n, ram_dq_oe, init_done, req_ready},
            5'b11000);
        chk("rst_mid_wr_state", dut.r_state, ST_POWERUP);
        @(negedge clk);
        reset = 1'b0;
        rel   = cyc;
        n     = 0;
        while (!init_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reinit_cycle", cyc - rel, T_PU);
        issue(1'b0, 1'b0, 23'h000123, 16'h0, 2'b00, 16'hA511, 1'b0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("sb_empty_at_end", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
